// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code constants, decoder
// state encoding, event-word layout and small byte-classification helpers.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int EV_CODE_W = 8;
  localparam int EV_W      = EV_CODE_W + 2;

  localparam int         ST_W       = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  // Keyboard-to-host status replies that carry no key information.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

  function automatic logic [EV_W-1:0] make_event(input logic ext, input logic brk,
                                                  input logic [EV_CODE_W-1:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// Synchronous show-ahead FIFO holding decoded key events; the head entry is
// presented combinationally and reads as zero while the FIFO is empty.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; only the pointers define validity, and dout is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns raw PS/2 scan-code bytes into {ext, brk, code} key events, stripping
// E0/F0/E1 prefixes, and queues them behind a valid/ready handshake.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAUSE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  output logic       err
);

  localparam int CW = $clog2(PAUSE_LEN) + 1;

  logic [ST_W-1:0] state, next_state;
  logic [CW-1:0]   skip_cnt, next_cnt;
  logic            push;
  logic [EV_W-1:0] ev;
  logic            err_d;
  logic            empty, full, pop;
  logic [EV_W-1:0] head;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    next_cnt   = skip_cnt;
    push       = 1'b0;
    ev         = '0;
    err_d      = 1'b0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (is_err_byte(byte_in)) begin
            err_d = 1'b1;
          end else if (byte_in == PS2_EXT) begin
            next_state = ST_EXT;
          end else if (byte_in == PS2_BRK) begin
            next_state = ST_BRK;
          end else if (byte_in == PS2_PAUSE) begin
            next_state = ST_PAUSE;
            next_cnt   = CW'(PAUSE_LEN - 2);
          end else if (!is_status_byte(byte_in)) begin
            push = 1'b1;
            ev   = make_event(1'b0, 1'b0, byte_in);
          end
        end
        ST_EXT: begin
          if (is_err_byte(byte_in)) begin
            err_d      = 1'b1;
            next_state = ST_IDLE;
          end else if (byte_in == PS2_BRK) begin
            next_state = ST_EXT_BRK;
          end else if (byte_in != PS2_EXT) begin
            push       = 1'b1;
            ev         = make_event(1'b1, 1'b0, byte_in);
            next_state = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          next_state = ST_IDLE;
          if (is_err_byte(byte_in)) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            ev   = make_event(state == ST_EXT_BRK, 1'b1, byte_in);
          end
        end
        ST_PAUSE: begin
          // Pause bytes are counted, never inspected; the last one emits the single E1 event.
          if (skip_cnt == '0) begin
            push       = 1'b1;
            ev         = make_event(1'b0, 1'b0, PS2_PAUSE);
            next_state = ST_IDLE;
          end else begin
            next_cnt = skip_cnt - CW'(1);
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign pop = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= next_state;
      skip_cnt <= next_cnt;
      overflow <= push && full && !pop;
      err      <= err_d;
    end
  end

  key_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (ev),
    .pop  (pop),
    .dout (head),
    .empty(empty),
    .full (full)
  );

  assign key_valid                   = !empty;
  assign {key_ext, key_brk, key_code} = head;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios with literal expectations plus
// random byte/ready traffic checked every cycle against a queue-based model.
module tb_ps2_key_decoder;

  localparam int DEPTH     = 4;
  localparam int PAUSE_LEN = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_key_decoder #(
    .DEPTH    (DEPTH),
    .PAUSE_LEN(PAUSE_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_brk   (key_brk),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending-prefix flags, a count of pause bytes still owed,
  // and a plain queue standing in for the event FIFO.
  logic [9:0] mq[$];
  bit         pend_ext, pend_brk;
  int         pause_left;
  bit         exp_ovf, exp_err;

  task automatic model_clear();
    mq.delete();
    pend_ext   = 0;
    pend_brk   = 0;
    pause_left = 0;
    exp_ovf    = 0;
    exp_err    = 0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy);
    bit         have_ev;
    logic [9:0] e;
    have_ev = 0;
    e       = '0;
    exp_ovf = 0;
    exp_err = 0;
    if (bv) begin
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) begin have_ev = 1; e = {2'b00, 8'hE1}; end
      end else if (b == 8'h00 || b == 8'hFF) begin
        exp_err = 1; pend_ext = 0; pend_brk = 0;
      end else if (pend_brk) begin
        have_ev = 1; e = {pend_ext, 1'b1, b}; pend_ext = 0; pend_brk = 0;
      end else if (b == 8'hE0) begin
        pend_ext = 1;
      end else if (b == 8'hF0) begin
        pend_brk = 1;
      end else if (!pend_ext && b == 8'hE1) begin
        pause_left = PAUSE_LEN - 1;
      end else if (!pend_ext && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
        // status reply, no event
      end else begin
        have_ev = 1; e = {pend_ext, 1'b0, b}; pend_ext = 0;
      end
    end
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (have_ev) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else exp_ovf = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else        model_step(byte_valid, byte_in, key_ready);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("key_valid", key_valid, mq.size() != 0);
      if (mq.size() != 0) check("head_event", {key_ext, key_brk, key_code}, mq[0]);
      check("overflow", overflow, exp_ovf);
      check("err", err, exp_err);
    end
  end

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  logic [7:0] pause_seq[8];
  logic [7:0] specials[9];

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    specials  = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    key_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {key_valid, overflow, err, key_ext, key_brk, key_code}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // make then break of a plain key
    key_ready = 1'b1;
    send(8'h1C);
    check("make_1C", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b00, 8'h1C});
    @(negedge clk);
    check("make_1C_one_cycle", key_valid, 1'b0);
    send(8'hF0);
    send(8'h1C);
    check("break_1C", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b01, 8'h1C});
    @(negedge clk);

    // extended make and break
    send(8'hE0); send(8'h75);
    check("ext_make_75", {key_ext, key_brk, key_code}, {2'b10, 8'h75});
    @(negedge clk);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break_75", {key_ext, key_brk, key_code}, {2'b11, 8'h75});
    @(negedge clk);

    // pause sequence collapses to one E1 event
    for (int i = 0; i < 7; i++) send(pause_seq[i]);
    check("pause_no_early_event", key_valid, 1'b0);
    send(pause_seq[7]);
    check("pause_event", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b00, 8'hE1});
    @(negedge clk);
    send(8'h1C);
    check("after_pause_1C", {key_ext, key_brk, key_code}, {2'b00, 8'h1C});
    @(negedge clk);

    // overflow with consumer stalled
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
    check("overflow_pulse", overflow, 1'b1);
    check("overflow_head_kept", key_code, 8'h15);
    @(negedge clk);
    check("overflow_one_cycle", overflow, 1'b0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", key_code, 8'h15 + 8'(i));
      @(negedge clk);
    end
    check("drained_empty", key_valid, 1'b0);

    // status and error bytes
    send(8'hAA);
    check("status_no_event", key_valid, 1'b0);
    send(8'hFF);
    check("err_pulse", {err, key_valid}, 2'b10);
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);

    // reset discards a pending E0 prefix
    key_ready = 1'b0;
    send(8'hE0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clears", {key_valid, overflow, err}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h1C);
    check("reset_drops_prefix", {key_ext, key_brk, key_code}, {2'b00, 8'h1C});
    key_ready = 1'b1;
    @(negedge clk);

    // full FIFO with simultaneous pop and push
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i));
    key_ready  = 1'b1;
    byte_in    = 8'h2A;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    check("full_pop_push_no_ovf", overflow, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("full_pop_order", key_code, 8'h22 + 8'(i));
      @(negedge clk);
    end
    check("tail_2A", {key_valid, key_code}, {1'b1, 8'h2A});
    @(negedge clk);

    // random traffic against the model, with one reset in the middle
    for (int c = 0; c < 4000; c++) begin
      byte_valid = ($urandom_range(0, 2) != 0);
      byte_in    = ($urandom_range(0, 9) < 4) ? specials[$urandom_range(0, 8)] : 8'($urandom);
      key_ready  = ((c / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if (c == 2000) rst_n = 1'b0;
      if (c == 2001) rst_n = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    key_ready  = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    check("final_empty", key_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
